// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for sram_bus_arbiter: FSM state encoding and stall width.
package sram_bus_arbiter_pkg;

  localparam int unsigned ARB_STATE_W  = 3;
  localparam int unsigned ARB_STALL_WD = 1;
  localparam int unsigned ARB_STRB_W   = 4;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_WAIT = 3'd4,
    ST_DONE   = 3'd5
  } arb_state_e;

endpackage

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one memory bus between instruction fetch and data
// access. Data goes first, then the fetch; the pipeline is stalled while any
// access is in flight and released for exactly one cycle (DONE) with the
// registered read data valid.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst_sram_*         fetch request (en/addr) and registered fetch data
//   data_sram_*         data request (en/wen/addr/wdata) and registered load data
//   stallreq            combinational stall request to the stall controller
//   bus_req/wr/wstrb/addr/wdata   combinational bus request fields
//   bus_addr_ok/data_ok/rdata     bus handshake and read data
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_sram_en,
  input  logic [ADDR_W-1:0]     inst_sram_addr,
  output logic [DATA_W-1:0]     inst_sram_rdata,
  input  logic                  data_sram_en,
  input  logic [ARB_STRB_W-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [ARB_STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  arb_state_e        state_q, state_d;
  logic              inst_pend_q, inst_pend_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [ARB_STALL_WD-1:0] stall_c;

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inst_pend_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_pend_q  <= inst_pend_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Next-state, pending-fetch latch and read-data capture.
  always_comb begin
    state_d      = state_q;
    inst_pend_d  = inst_pend_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    stall_c      = '0;
    unique case (state_q)
      ST_IDLE: begin
        stall_c = ARB_STALL_WD'(inst_sram_en | data_sram_en);
        if (data_sram_en) begin
          state_d     = ST_D_REQ;
          inst_pend_d = inst_sram_en;
        end else if (inst_sram_en) begin
          state_d     = ST_I_REQ;
          inst_pend_d = 1'b0;
        end
      end
      ST_D_REQ: begin
        stall_c = '1;
        if (bus_addr_ok) state_d = ST_D_WAIT;
      end
      ST_D_WAIT: begin
        stall_c = '1;
        if (bus_data_ok) begin
          // Writes complete without touching the load-data register.
          if (data_sram_wen == '0) data_rdata_d = bus_rdata;
          state_d = inst_pend_q ? ST_I_REQ : ST_DONE;
        end
      end
      ST_I_REQ: begin
        stall_c = '1;
        if (bus_addr_ok) state_d = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        stall_c = '1;
        if (bus_data_ok) begin
          inst_rdata_d = bus_rdata;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        inst_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bus_mux: drive request fields from the held data or fetch inputs.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (state_q == ST_D_REQ) begin
      bus_req   = 1'b1;
      bus_wr    = |data_sram_wen;
      bus_wstrb = data_sram_wen;
      bus_addr  = data_sram_addr;
      bus_wdata = data_sram_wdata;
    end else if (state_q == ST_I_REQ) begin
      bus_req   = 1'b1;
      bus_addr  = inst_sram_addr;
    end
  end

  assign stallreq        = stall_c[0];
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .stallreq       (stallreq),
    .bus_req        (bus_req),
    .bus_wr         (bus_wr),
    .bus_wstrb      (bus_wstrb),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_addr_ok    (bus_addr_ok),
    .bus_data_ok    (bus_data_ok),
    .bus_rdata      (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_sram_en = 1'b0; inst_sram_addr = '0;
    data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_data_rdata", data_sram_rdata, 32'd0);

    // Inst-only fetch.
    tick();
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000; #1;
    chk("i_idle_stall", 32'(stallreq), 32'd1);
    chk("i_idle_req", 32'(bus_req), 32'd0);
    tick();                                  // I_REQ
    bus_addr_ok = 1'b1; #1;
    chk("i_req_req", 32'(bus_req), 32'd1);
    chk("i_req_addr", bus_addr, 32'hBFC00000);
    chk("i_req_wr", 32'(bus_wr), 32'd0);
    chk("i_req_stall", 32'(stallreq), 32'd1);
    tick();                                  // I_WAIT
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C080001; #1;
    chk("i_wait_req", 32'(bus_req), 32'd0);
    chk("i_wait_stall", 32'(stallreq), 32'd1);
    tick();                                  // DONE
    bus_data_ok = 1'b0; #1;
    chk("i_done_stall", 32'(stallreq), 32'd0);
    chk("i_done_rdata", inst_sram_rdata, 32'h3C080001);
    inst_sram_en = 1'b0;
    tick();                                  // IDLE

    // Load followed by fetch.
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80001000;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00004; #1;
    chk("lf_idle_stall", 32'(stallreq), 32'd1);
    tick();                                  // D_REQ
    bus_addr_ok = 1'b1; #1;
    chk("lf_dreq_req", 32'(bus_req), 32'd1);
    chk("lf_dreq_addr", bus_addr, 32'h80001000);
    chk("lf_dreq_wr", 32'(bus_wr), 32'd0);
    tick();                                  // D_WAIT
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678; #1;
    chk("lf_dwait_req", 32'(bus_req), 32'd0);
    chk("lf_dwait_stall", 32'(stallreq), 32'd1);
    tick();                                  // I_REQ
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1; #1;
    chk("lf_ireq_addr", bus_addr, 32'hBFC00004);
    chk("lf_ireq_stall", 32'(stallreq), 32'd1);
    chk("lf_data_rdata", data_sram_rdata, 32'h12345678);
    tick();                                  // I_WAIT
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24090002; #1;
    chk("lf_iwait_stall", 32'(stallreq), 32'd1);
    tick();                                  // DONE
    bus_data_ok = 1'b0; #1;
    chk("lf_done_stall", 32'(stallreq), 32'd0);
    chk("lf_done_inst", inst_sram_rdata, 32'h24090002);
    chk("lf_done_data", data_sram_rdata, 32'h12345678);
    data_sram_en = 1'b0; inst_sram_en = 1'b0;
    tick();                                  // IDLE

    // Store with backpressure and spurious data_ok.
    data_sram_en = 1'b1; data_sram_wen = 4'b0011; data_sram_addr = 32'h80002000;
    data_sram_wdata = 32'hAABBCCDD; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
    chk("st_idle_stall", 32'(stallreq), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();                                // D_REQ, addr_ok withheld
      chk("bp_req", 32'(bus_req), 32'd1);
      chk("bp_addr", bus_addr, 32'h80002000);
      chk("bp_wdata", bus_wdata, 32'hAABBCCDD);
      chk("bp_wr", 32'(bus_wr), 32'd1);
      chk("bp_wstrb", 32'(bus_wstrb), 32'h3);
      chk("bp_stall", 32'(stallreq), 32'd1);
      chk("bp_data_rdata", data_sram_rdata, 32'h12345678);
    end
    tick();                                  // still D_REQ
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1; #1;
    chk("st_dreq_req", 32'(bus_req), 32'd1);
    tick();                                  // D_WAIT
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    chk("st_dwait_stall", 32'(stallreq), 32'd1);
    tick();                                  // DONE
    bus_data_ok = 1'b0; #1;
    chk("st_done_stall", 32'(stallreq), 32'd0);
    chk("st_done_data", data_sram_rdata, 32'h12345678);
    data_sram_en = 1'b0; data_sram_wen = 4'b0000;
    tick();                                  // IDLE

    // Reset in the middle of a load.
    data_sram_en = 1'b1; data_sram_addr = 32'h80003000;
    tick();                                  // D_REQ
    bus_addr_ok = 1'b1; #1;
    chk("rm_dreq_req", 32'(bus_req), 32'd1);
    tick();                                  // D_WAIT
    bus_addr_ok = 1'b0; #1;
    chk("rm_dwait_req", 32'(bus_req), 32'd0);
    chk("rm_dwait_stall", 32'(stallreq), 32'd1);
    rst = 1'b1; data_sram_en = 1'b0;
    tick();
    chk("rm_bus_req", 32'(bus_req), 32'd0);
    chk("rm_stall", 32'(stallreq), 32'd0);
    chk("rm_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rm_data_rdata", data_sram_rdata, 32'd0);
    rst = 1'b0;
    tick();
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00008; #1;
    chk("rm_idle_stall", 32'(stallreq), 32'd1);
    chk("rm_idle_req", 32'(bus_req), 32'd0);
    tick();                                  // I_REQ proves FSM restarted from IDLE
    chk("rm_ireq_req", 32'(bus_req), 32'd1);
    chk("rm_ireq_addr", bus_addr, 32'hBFC00008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one unified memory bus port between the core's instruction-fetch request and its data-access request.
- Serialises the two requests: data first, then instruction. Each request uses an addr_ok/data_ok handshake on the bus.
- Raises a stall request to the pipeline controller for as long as any access is in flight.
- Sits between the core's inst/data SRAM-style interfaces and the external bus. Its stallreq output is ORed into the stall controller alongside the load-use stall request.

Parameters:
- ADDR_W, 32, address width of core requests and the bus.
- DATA_W, 32, data width of read/write data.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- inst_sram_en  input  1  fetch request valid; held stable while stallreq=1
- inst_sram_addr  input  ADDR_W  fetch address
- inst_sram_rdata  output  DATA_W  registered fetch data
- data_sram_en  input  1  data request valid; held stable while stallreq=1
- data_sram_wen  input  4  byte write strobes; 0 means read
- data_sram_addr  input  ADDR_W  data address
- data_sram_wdata  input  DATA_W  store data
- data_sram_rdata  output  DATA_W  registered load data
- stallreq  output  1  stall request to the stall controller
- bus_req  output  1  bus request valid
- bus_wr  output  1  1 = write
- bus_wstrb  output  4  write byte strobes
- bus_addr  output  ADDR_W  bus address
- bus_wdata  output  DATA_W  bus write data
- bus_addr_ok  input  1  request accepted this cycle
- bus_data_ok  input  1  response / write-complete this cycle
- bus_rdata  input  DATA_W  read data, valid with bus_data_ok

Behaviour:
- Reset (synchronous): state=IDLE; bus_req=0; bus_wr=0; bus_wstrb=0; bus_addr=0; bus_wdata=0; inst_sram_rdata=0; data_sram_rdata=0; stallreq=0; inst_pend=0.
- States and transitions:
  - IDLE:
    - data_sram_en=1 → D_REQ; latch inst_pend=inst_sram_en.
    - data_sram_en=0 and inst_sram_en=1 → I_REQ.
    - neither → stay in IDLE.
  - D_REQ: bus_req=1 with data fields; bus_wr=|data_sram_wen. bus_addr_ok=1 → D_WAIT.
  - D_WAIT: bus_req=0. bus_data_ok=1 → capture bus_rdata into data_sram_rdata (reads only; writes leave it unchanged). Then go to I_REQ if inst_pend, else DONE.
  - I_REQ: bus_req=1, bus_wr=0, bus_wstrb=0, addr=inst_sram_addr. bus_addr_ok=1 → I_WAIT.
  - I_WAIT: bus_data_ok=1 → capture inst_sram_rdata → DONE.
  - DONE: one cycle, then unconditionally IDLE. Requests still present in this cycle are not re-issued.
- stallreq (combinational):
  - 1 in IDLE when (inst_sram_en|data_sram_en).
  - 1 in D_REQ, D_WAIT, I_REQ and I_WAIT.
  - 0 in DONE, so the pipeline advances exactly one cycle with the registered rdata valid.
- Bus request fields are driven combinationally from the current state and held inputs. They stay stable while bus_req=1 and bus_addr_ok=0.
- bus_data_ok is honoured only in the *_WAIT states. The bus guarantees data_ok arrives no earlier than the cycle after addr_ok.
- Minimum latency, with addr_ok and data_ok each on their first possible cycle:
  - inst-only: 3 stalled cycles (IDLE, I_REQ, I_WAIT) + DONE.
  - data+inst: 5 stalled cycles + DONE.
- Reset mid-operation returns to IDLE immediately and drops bus_req. The bus is reset by the same rst, so no stale data_ok follows.
- rdata registers hold their value until the next corresponding capture.

Decomposition:
- Shared defines header:
  - state encoding constants (IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE; 3 bits);
  - ARB_STALL_WD, the stall-request width.
- No sub-module. A single FSM plus capture registers is natural.
- A bus_mux combinational block selects the inst vs data fields inside the module.

Test Plan:
- Inst-only: inst_sram_en=1, addr=0xBFC00000; addr_ok on the first I_REQ cycle; data_ok next cycle with rdata=0x3C080001 → inst_sram_rdata=0x3C080001 in DONE; stallreq high 3 cycles then low 1.
- Load+fetch: data_en=1, wen=0, addr=0x80001000; inst addr=0xBFC00004 → bus sees data read first, then inst. data_sram_rdata=0x12345678, inst_sram_rdata=0x24090002; stallreq low only in DONE.
- Store: wen=4'b0011, wdata=0xAABBCCDD → bus_wr=1, wstrb=0011, wdata passed through; data_sram_rdata unchanged.
- Backpressure: hold bus_addr_ok=0 for 4 cycles in D_REQ → bus_req/addr/wdata stable every cycle; stallreq stays 1.
- Spurious data_ok: bus_data_ok=1 while in IDLE/D_REQ → ignored; rdata unchanged.
- Reset mid-op: assert rst in D_WAIT → next cycle state=IDLE, bus_req=0, stallreq=0, both rdata=0.
